// File: rtl/cont_assign_pkg.sv
// Shared types and widths for the cont_assign characterization sequencer.
package cont_assign_pkg;

    localparam int VEC_W = 3;
    localparam int RES_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        DWELL,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/cont_assign.sv
// Combinational 3-input logic unit under characterization (inputs a/b/c, outputs w/x/y/z).
module cont_assign (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic w,
    output logic x,
    output logic y,
    output logic z
);

    assign w = a & b;
    assign x = b | c;
    assign y = a ^ b ^ c;
    assign z = ~(a | c);

endmodule

// File: rtl/cont_assign_pat_ram.sv
// Pattern table: DEPTH slots of {vec, dwell}, one write port, one asynchronous read port.
module cont_assign_pat_ram
    import cont_assign_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [VEC_W-1:0]           wvec,
    input  logic [DWELL_W-1:0]         wdwell,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [VEC_W-1:0]           rvec,
    output logic [DWELL_W-1:0]         rdwell
);

    logic [VEC_W-1:0]   vec_q   [DEPTH];
    logic [VEC_W-1:0]   vec_d   [DEPTH];
    logic [DWELL_W-1:0] dwell_q [DEPTH];
    logic [DWELL_W-1:0] dwell_d [DEPTH];

    always_comb begin
        vec_d   = vec_q;
        dwell_d = dwell_q;
        if (we) begin
            vec_d[waddr]   = wvec;
            dwell_d[waddr] = wdwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vec_q[i]   <= '0;
                dwell_q[i] <= '0;
            end
        end else begin
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
        end
    end

    assign rvec   = vec_q[raddr];
    assign rdwell = dwell_q[raddr];

endmodule

// File: rtl/cont_assign_seq.sv
// Sequencer that steps the logic unit through programmed vectors, holding each for a
// programmable dwell and streaming the captured {w,x,y,z} response with its step index.
module cont_assign_seq
    import cont_assign_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [VEC_W-1:0]           cfg_vec,
    input  logic [DWELL_W-1:0]         cfg_dwell,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       abort,
    output logic                       a,
    output logic                       b,
    output logic                       c,
    input  logic                       w,
    input  logic                       x,
    input  logic                       y,
    input  logic                       z,
    output logic                       busy,
    output logic                       done,
    output logic                       res_valid,
    output logic [$clog2(DEPTH)-1:0]   res_idx,
    output logic [RES_W-1:0]           res_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        n_q, n_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [AW-1:0]      res_idx_q, res_idx_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;

    logic               ram_we;
    logic [AW-1:0]      rd_addr;
    logic [VEC_W-1:0]   rd_vec;
    logic [DWELL_W-1:0] rd_dwell;
    logic               run_req;
    logic               last_step;
    logic               aborting;

    function automatic logic [AW:0] clamp_steps(input logic [AW:0] req);
        return (req > DEPTH_N) ? DEPTH_N : req;
    endfunction

    // The table is frozen while a run is in progress.
    assign ram_we    = cfg_we && (state_q == IDLE);
    assign run_req   = start && (num_steps != '0);
    assign last_step = ({1'b0, idx_q} == (n_q - (AW + 1)'(1)));
    assign aborting  = abort && (state_q != IDLE);

    // The single read port serves slot 0 at start, the next slot in CAPTURE, else the current one.
    always_comb begin
        rd_addr = idx_q;
        if (state_q == IDLE) begin
            rd_addr = '0;
        end else if (state_q == CAPTURE) begin
            rd_addr = idx_q + AW'(1);
        end
    end

    cont_assign_pat_ram #(
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) u_pat_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (ram_we),
        .waddr  (cfg_addr),
        .wvec   (cfg_vec),
        .wdwell (cfg_dwell),
        .raddr  (rd_addr),
        .rvec   (rd_vec),
        .rdwell (rd_dwell)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (run_req) state_d = APPLY;
                APPLY:   state_d = DWELL;
                DWELL:   if (cnt_q == '0) state_d = CAPTURE;
                CAPTURE: state_d = last_step ? DONE : APPLY;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        vec_d       = vec_q;
        idx_d       = idx_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_data_d  = res_data_q;
        case (state_q)
            IDLE: begin
                vec_d = '0;
                if (run_req) begin
                    n_d   = clamp_steps(num_steps);
                    idx_d = '0;
                    // A same-cycle write to slot 0 must be seen by this run.
                    vec_d = (cfg_we && (cfg_addr == '0)) ? cfg_vec : rd_vec;
                end
            end
            APPLY: cnt_d = rd_dwell;
            DWELL: if (cnt_q != '0) cnt_d = cnt_q - DWELL_W'(1);
            CAPTURE: begin
                res_data_d  = {w, x, y, z};
                res_idx_d   = idx_q;
                res_valid_d = 1'b1;
                if (last_step) begin
                    vec_d = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                    vec_d = rd_vec;
                end
            end
            DONE:    vec_d = '0;
            default: vec_d = '0;
        endcase
        if (aborting) begin
            vec_d       = '0;
            idx_d       = idx_q;
            cnt_d       = cnt_q;
            res_valid_d = 1'b0;
            res_idx_d   = res_idx_q;
            res_data_d  = res_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
        end else begin
            vec_q       <= vec_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        {a, b, c} = vec_q;
        res_valid = res_valid_q;
        res_idx   = res_idx_q;
        res_data  = res_data_q;
    end

endmodule

// File: tb/tb_cont_assign_seq.sv
// Bench for cont_assign_seq driving the cont_assign logic unit, checked against a timeline model.
module tb_cont_assign_seq;

    localparam int DEPTH   = 8;
    localparam int DWELL_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [2:0] cfg_vec;
    logic [3:0] cfg_dwell;
    logic       start;
    logic [3:0] num_steps;
    logic       abort;
    logic       a, b, c, w, x, y, z;
    logic       busy, done, res_valid;
    logic [2:0] res_idx;
    logic [3:0] res_data;

    always #5 clk = ~clk;

    cont_assign_seq #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vec(cfg_vec),
        .cfg_dwell(cfg_dwell), .start(start), .num_steps(num_steps), .abort(abort),
        .a(a), .b(b), .c(c), .w(w), .x(x), .y(y), .z(z), .busy(busy), .done(done),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    cont_assign u_lu (.a(a), .b(b), .c(c), .w(w), .x(x), .y(y), .z(z));

    typedef struct {
        logic       busy;
        logic       done;
        logic [2:0] abc;
        logic       rv;
        logic [2:0] ridx;
        logic [3:0] rdata;
    } exp_t;

    typedef struct {
        logic [2:0] vec;
        logic [3:0] dw;
        logic [3:0] res;
    } vec_rec_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       tl [256];
    logic [2:0] sh_vec [8];
    logic [3:0] sh_dw [8];
    logic [3:0] lut [8];
    logic [3:0] got [8];
    vec_rec_t   tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected cycle-by-cycle trace, cycle 0 being the cycle start is presented.
    task automatic build_model(input int n_req, input int abort_cyc, output int len);
        int n;
        int t;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        for (int i = 0; i < 256; i++) tl[i] = '{1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 4'h0};
        t = 1;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < int'(sh_dw[s]) + 3; k++) begin
                tl[t + k].busy = 1'b1;
                tl[t + k].abc  = sh_vec[s];
            end
            t = t + int'(sh_dw[s]) + 3;
            tl[t].rv    = 1'b1;
            tl[t].ridx  = 3'(s);
            tl[t].rdata = lut[sh_vec[s]];
        end
        if (n > 0) begin
            tl[t].busy = 1'b1;
            tl[t].done = 1'b1;
        end
        len = t + 2;
        if (abort_cyc >= 0) begin
            for (int i = abort_cyc + 1; i < 256; i++) tl[i] = '{1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 4'h0};
        end
    endtask

    task automatic write_slot(input logic [2:0] addr, input logic [2:0] v, input logic [3:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = addr; cfg_vec = v; cfg_dwell = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        sh_vec[addr] = v;
        sh_dw[addr]  = d;
    endtask

    task automatic run(input string tag, input int n_req, input int abort_cyc, input int busy_wr_cyc,
                       input bit same_wr, input logic [2:0] sw_vec);
        int len;
        logic [2:0] wa;
        if (same_wr) sh_vec[0] = sw_vec;
        build_model(n_req, abort_cyc, len);
        @(posedge clk); #1;
        start = 1'b1;
        num_steps = 4'(n_req);
        if (same_wr) begin
            cfg_we = 1'b1; cfg_addr = 3'd0; cfg_vec = sw_vec; cfg_dwell = sh_dw[0];
        end
        for (int cyc = 1; cyc <= len; cyc++) begin
            @(posedge clk); #1;
            start  = 1'b0;
            cfg_we = 1'b0;
            abort  = (cyc == abort_cyc);
            if (cyc == busy_wr_cyc) begin
                wa = 3'($urandom_range(0, 7));
                cfg_we = 1'b1; cfg_addr = wa; cfg_vec = ~sh_vec[wa]; cfg_dwell = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            check($sformatf("%s ctl@%0d", tag, cyc), {busy, done, a, b, c, res_valid},
                  {tl[cyc].busy, tl[cyc].done, tl[cyc].abc, tl[cyc].rv});
            if (tl[cyc].rv) begin
                check($sformatf("%s res@%0d", tag, cyc), {res_idx, res_data}, {tl[cyc].ridx, tl[cyc].rdata});
                got[res_idx] = res_data;
            end
        end
        @(posedge clk); #1;
        abort  = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        int n_rand;
        int ab;
        lut = '{4'b0001, 4'b0110, 4'b0111, 4'b0100, 4'b0010, 4'b0100, 4'b1100, 4'b1110};
        tbl = '{'{3'b000, 4'd0, 4'b0001}, '{3'b001, 4'd1, 4'b0110}, '{3'b010, 4'd2, 4'b0111},
                '{3'b011, 4'd0, 4'b0100}, '{3'b100, 4'd3, 4'b0010}, '{3'b101, 4'd0, 4'b0100},
                '{3'b110, 4'd1, 4'b1100}, '{3'b111, 4'd0, 4'b1110}};
        for (int i = 0; i < 8; i++) begin
            sh_vec[i] = '0; sh_dw[i] = '0; got[i] = '0;
        end
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_vec = '0; cfg_dwell = '0;
        start = 1'b0; num_steps = '0; abort = 1'b0;
        #12;
        check("reset outs", {busy, done, a, b, c, res_valid, res_idx, res_data}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Basic three-step run
        write_slot(3'd0, 3'b011, 4'd0);
        write_slot(3'd1, 3'b101, 4'd0);
        write_slot(3'd2, 3'b010, 4'd0);
        run("basic", 3, -1, -1, 1'b0, 3'b000);
        check("basic r0", got[0], 4'b0100);
        check("basic r1", got[1], 4'b0100);
        check("basic r2", got[2], 4'b0111);

        // Maximum dwell, then zero steps
        write_slot(3'd0, 3'b111, 4'd15);
        run("dwell", 1, -1, -1, 1'b0, 3'b000);
        check("dwell r0", got[0], 4'b1110);
        run("zero", 0, -1, -1, 1'b0, 3'b000);

        // Full table, num_steps clamped to DEPTH
        for (int i = 0; i < 8; i++) write_slot(3'(i), tbl[i].vec, tbl[i].dw);
        for (int i = 0; i < 8; i++) got[i] = 4'hf;
        run("clamp", 15, -1, -1, 1'b0, 3'b000);
        for (int i = 0; i < 8; i++) check($sformatf("tbl r%0d", i), got[i], tbl[i].res);

        // Abort during DWELL of step 1
        write_slot(3'd0, 3'b001, 4'd2);
        write_slot(3'd1, 3'b110, 4'd2);
        write_slot(3'd2, 3'b100, 4'd2);
        run("abort", 3, 8, -1, 1'b0, 3'b000);

        // Write attempted while busy, then rerun to see the table unchanged
        run("busywr", 3, -1, 3, 1'b0, 3'b000);
        run("rerun", 3, -1, -1, 1'b0, 3'b000);

        // Write to slot 0 in the same cycle as start
        run("samewr", 1, -1, -1, 1'b1, 3'b101);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) write_slot(3'(i), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)));
            n_rand = $urandom_range(0, 10);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
            run($sformatf("rnd%0d", it), n_rand, ab, -1, 1'b0, 3'b000);
        end

        // Reset dropped during CAPTURE
        write_slot(3'd0, 3'b110, 4'd0);
        @(posedge clk); #1; start = 1'b1; num_steps = 4'd1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        check("rst async", {busy, done, a, b, c, res_valid, res_idx, res_data}, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sh_vec[i] = '0; sh_dw[i] = '0;
        end
        got[0] = 4'hf;
        run("postrst", 1, -1, -1, 1'b0, 3'b000);
        check("postrst r0", got[0], 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cont_assign_seq.md
# cont_assign_seq

Sequencer that drives the 3-input continuous-assignment logic unit (inputs a/b/c, outputs w/x/y/z) through a programmed list of input vectors. Each vector is held for a programmable dwell time, and the unit's 4-bit response is then captured and streamed out with its step index. It replaces hand-written `#delay` stimulus with a synthesizable, repeatable characterization engine that sits directly in front of the logic unit.

## Interface
Parameters:
- DEPTH, 8: number of pattern slots; a power of 2, at least 2.
- DWELL_W, 4: width of the per-step dwell count.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  write the pattern slot at cfg_addr; ignored while busy.
- cfg_addr  in  $clog2(DEPTH)  slot index.
- cfg_vec  in  3  {a,b,c} vector for the slot.
- cfg_dwell  in  DWELL_W  extra hold cycles for the slot.
- start  in  1  begin a run; sampled in IDLE only.
- num_steps  in  $clog2(DEPTH)+1  steps to run, sampled with start.
- abort  in  1  synchronous abort of a run.
- a, b, c  out  1 each  registered drive to the logic unit.
- w, x, y, z  in  1 each  logic unit outputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes.
- res_valid  out  1  one-cycle pulse per captured result.
- res_idx  out  $clog2(DEPTH)  step index of the result.
- res_data  out  4  captured {w,x,y,z}.

## Operation
States are IDLE, APPLY, DWELL, CAPTURE and DONE.

- **IDLE**
  - {a,b,c}=000 and busy=0.
  - start with num_steps==0: ignored.
  - start with num_steps>DEPTH: n is clamped to DEPTH.
  - Otherwise: latch n, set idx=0, go to APPLY.
- **APPLY** (1 cycle)
  - {a,b,c}=vec[idx] is already valid; it is loaded on the edge entering APPLY.
  - Load cnt=dwell[idx], go to DWELL.
- **DWELL**
  - cnt==0: go to CAPTURE.
  - Otherwise: cnt decrements.
  - Total DWELL occupancy is dwell+1 cycles.
- **CAPTURE** (1 cycle)
  - Register {w,x,y,z} into res_data and idx into res_idx.
  - res_valid is high in the following cycle.
  - idx==n-1: go to DONE.
  - Otherwise: idx++, go to APPLY.
  - {a,b,c} loads the next vector on this edge.
- **DONE** (1 cycle)
  - done=1; go to IDLE, where {a,b,c} becomes 000.

General rules:
- {a,b,c} holds its value from APPLY through CAPTURE of each step; it never changes mid-step.
- abort in any non-IDLE state:
  - Next state is IDLE with {a,b,c}=000 and no done pulse.
  - A res_valid already scheduled by a preceding CAPTURE still fires.
  - abort has priority over every other transition.
- start or cfg_we while busy is ignored; the pattern table is read-only during a run.
- cfg_we and start in the same IDLE cycle: the write takes effect first, so the run uses the new slot contents.

## Timing
Reset values (asynchronous): state=IDLE, {a,b,c}=000, busy=0, done=0, res_valid=0, res_idx=0, res_data=0, idx=0, cnt=0. All pattern slots reset to vec=000, dwell=0.

Latencies:
- From start to the first vector on a/b/c: 1 cycle.
- Cycles per step: dwell+3.
- From the CAPTURE of step i to res_valid for step i: 1 cycle.
- Run length: sum of (dwell_i+3) + 1 cycle for DONE.

Handshake and boundaries:
- The last res_valid coincides with the DONE cycle.
- No backpressure: a consumer must accept res_valid every cycle.
- The logic unit is combinational and must settle within APPLY+DWELL. dwell=0 still provides 2 settle cycles.
- dwell at its maximum (2^DWELL_W-1): the counter must not wrap.
- Reset asserted mid-run: outputs take their reset values immediately, with no done pulse. Pattern contents are lost.

## Structure
- Shared package cont_assign_pkg:
  - state enum (IDLE, APPLY, DWELL, CAPTURE, DONE);
  - vector width constant VEC_W=3;
  - result width constant RES_W=4.
- One sub-module: cont_assign_pat_ram, a DEPTH x (3+DWELL_W) register file.
  - One write port, one asynchronous read port.
  - Async reset to zero.
- The FSM, counters and output registers live in the top module.
- The bench instantiates cont_assign_seq driving the existing cont_assign logic unit.

## Test plan
Each scenario is stimulus -> required response.

- **Basic run:** slots 0..2 = (011, dwell 0), (101, dwell 0), (010, dwell 0); start with num_steps=3.
  - -> a/b/c shows 011, 101, 010, each held 3 cycles.
  - -> 3 res_valid pulses with res_idx 0, 1, 2, each res_data matching the logic unit's truth table.
  - -> done 1 cycle after the last CAPTURE.
  - -> busy high for 10 cycles in total.
- **Dwell:** slot 0 = (111, dwell 15); num_steps=1.
  - -> a/b/c=111 for 18 cycles.
  - -> res_valid at start+19, done in the same cycle.
- **Boundaries:**
  - num_steps=0 -> busy stays 0, no pulses.
  - num_steps=15 with DEPTH=8 -> exactly 8 results.
- **Abort:** assert abort during DWELL of step 1 of a 3-step run.
  - -> next cycle IDLE, a/b/c=000, res_valid only for step 0, no done.
- **Config during busy and same-cycle write:**
  - cfg_we during a run -> the slot is unchanged afterwards (read back by a rerun).
  - start with cfg_we to slot 0 in the same cycle -> the run uses the new vector.
- **Reset mid-run:** drop rst_n during CAPTURE.
  - -> all outputs are zero asynchronously, before the next clk edge.
  - -> after release, a start with num_steps=1 captures vec=000 with res_idx=0.
